// File: rtl/counter_pkg.sv
// Shared constants, state enum and scenario enum for the loadable range-checked counter.
package counter_pkg;

    localparam int WIDTH     = 4;
    localparam int MIN_COUNT = 3;
    localparam int MAX_COUNT = 6;

    typedef enum logic [2:0] {
        CT_IDLE   = 3'd0,
        CT_LOADED = 3'd1,
        CT_COUNT  = 3'd2,
        CT_WAIT   = 3'd3,
        CT_DONE   = 3'd4
    } ct_state_e;

    typedef enum logic [2:0] {
        SCN_RESET   = 3'd0,
        SCN_LOAD    = 3'd1,
        SCN_ILLEGAL = 3'd2,
        SCN_WAIT    = 3'd3,
        SCN_SIMUL   = 3'd4,
        SCN_WRAP    = 3'd5,
        SCN_RANDOM  = 3'd6
    } ct_scenario_e;

endpackage

// File: rtl/ct_load_counter_if.sv
// Driver/monitor interface of the counter: load commands in, count and status out.
interface ct_load_counter_if #(
    parameter int WIDTH = 4
);
    logic             ld;
    logic [WIDTH-1:0] data_in;
    logic             hold;
    logic [WIDTH-1:0] counter;
    logic             busy;
    logic             done;
    logic             load_err;

    modport master (
        output ld, data_in, hold,
        input  counter, busy, done, load_err
    );

    modport slave (
        input  ld, data_in, hold,
        output counter, busy, done, load_err
    );
endinterface

// File: rtl/ct_range_chk.sv
// Combinational inclusive unsigned window check of a load value against [MIN_COUNT, MAX_COUNT].
module ct_range_chk #(
    parameter int WIDTH     = 4,
    parameter int MIN_COUNT = 3,
    parameter int MAX_COUNT = 6
) (
    input  logic [WIDTH-1:0] data_in,
    output logic             in_range
);
    logic [31:0] value_s;

    // Widen before comparing so the bounds are compared as plain unsigned integers.
    always_comb begin
        value_s  = 32'(data_in);
        in_range = (value_s >= 32'(MIN_COUNT)) && (value_s <= 32'(MAX_COUNT));
    end
endmodule

// File: rtl/ct_load_counter.sv
// Loadable range-checked up-counter FSM; define CT_LOAD_COUNTER_WRAP_EN to wrap to MIN_COUNT
// after reaching MAX_COUNT instead of saturating in DONE.
module ct_load_counter #(
    parameter int WIDTH     = counter_pkg::WIDTH,
    parameter int MIN_COUNT = counter_pkg::MIN_COUNT,
    parameter int MAX_COUNT = counter_pkg::MAX_COUNT
) (
    input  logic               clk,
    input  logic               rst,
    ct_load_counter_if.slave   bus
);
    import counter_pkg::*;

`ifdef CT_LOAD_COUNTER_WRAP_EN
    localparam ct_state_e TERM_STATE = CT_COUNT;
`else
    localparam ct_state_e TERM_STATE = CT_DONE;
`endif

    ct_state_e        state_r;
    ct_state_e        next_state_s;
    logic [WIDTH-1:0] counter_r;
    logic [WIDTH-1:0] next_counter_s;
    logic [WIDTH-1:0] inc_s;
    logic             busy_r;
    logic             done_r;
    logic             load_err_r;
    logic             next_done_s;
    logic             next_err_s;
    logic             in_range_s;
    logic             at_max_s;
    logic             inc_max_s;

    ct_range_chk #(
        .WIDTH     (WIDTH),
        .MIN_COUNT (MIN_COUNT),
        .MAX_COUNT (MAX_COUNT)
    ) u_range_chk (
        .data_in  (bus.data_in),
        .in_range (in_range_s)
    );

    // Next-state, next-count and pulse decode; a load of any kind suspends counting that cycle.
    always_comb begin
        next_state_s   = state_r;
        next_counter_s = counter_r;
        next_done_s    = 1'b0;
        next_err_s     = 1'b0;
        inc_s          = counter_r + WIDTH'(1);
        at_max_s       = (counter_r == WIDTH'(MAX_COUNT));
        inc_max_s      = (inc_s == WIDTH'(MAX_COUNT));
        if (bus.ld) begin
            if (in_range_s) begin
                next_state_s   = CT_LOADED;
                next_counter_s = bus.data_in;
            end else begin
                next_err_s = 1'b1;
            end
        end else begin
            case (state_r)
                CT_LOADED, CT_COUNT: begin
                    if (state_r == CT_LOADED && at_max_s) begin
                        next_state_s = TERM_STATE;
                        next_done_s  = 1'b1;
                    end else if (bus.hold) begin
                        next_state_s = CT_WAIT;
                    end else if (at_max_s) begin
                        // Only reachable when wrapping: restart the window after the done cycle.
                        next_state_s   = CT_COUNT;
                        next_counter_s = WIDTH'(MIN_COUNT);
                        next_done_s    = (MIN_COUNT == MAX_COUNT);
                    end else begin
                        next_counter_s = inc_s;
                        next_done_s    = inc_max_s;
                        next_state_s   = inc_max_s ? TERM_STATE : CT_COUNT;
                    end
                end
                CT_WAIT: begin
                    if (bus.hold) begin
                        next_state_s = CT_WAIT;
                    end else begin
                        next_state_s = CT_COUNT;
                    end
                end
                CT_IDLE, CT_DONE: begin
                    next_state_s = state_r;
                end
                default: begin
                    next_state_s   = CT_IDLE;
                    next_counter_s = '0;
                end
            endcase
        end
    end

    // State, count and registered status outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= CT_IDLE;
            counter_r  <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            load_err_r <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            counter_r  <= next_counter_s;
            busy_r     <= (next_state_s == CT_LOADED) || (next_state_s == CT_COUNT) ||
                          (next_state_s == CT_WAIT);
            done_r     <= next_done_s;
            load_err_r <= next_err_s;
        end
    end

    assign bus.counter  = counter_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.load_err = load_err_r;
endmodule
